// File: rtl/sprite_line_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sprite_line_writer_pkg
// Brief   : Shared FSM encoding and default geometry for the sprite line writer.
// Revision: 1.0 - initial release
// ============================================================================
package sprite_line_writer_pkg;

    localparam int unsigned C_AW          = 10;
    localparam int unsigned C_DW          = 11;
    localparam int unsigned C_CW          = 4;
    localparam int unsigned C_LINE_W      = 512;
    localparam int unsigned C_TRANSPARENT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CHK  = 2'd2,
        ST_WR   = 2'd3
    } state_e;

endpackage : sprite_line_writer_pkg
`default_nettype wire

// File: rtl/sprite_line_writer_if.sv
`default_nettype none
// ============================================================================
// Module  : sprite_line_writer_if
// Brief   : Pixel handshake, line buffer write port and collision report bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface sprite_line_writer_if
    import sprite_line_writer_pkg::*;
#(
    parameter int AW = C_AW,
    parameter int DW = C_DW,
    parameter int CW = C_CW
) ();

    logic              pix_valid;
    logic              pix_ready;
    logic [AW-1:0]     pix_x;
    logic [DW-1:0]     pix_dat;
    logic              line_end;
    logic              line_done;
    logic [AW-1:0]     lb_wadr;
    logic [DW-1:0]     lb_wdat;
    logic              lb_we;
    logic [DW-1:0]     lb_rdat1;
    logic              coll_valid;
    logic [DW-CW-1:0]  coll_old;
    logic [DW-CW-1:0]  coll_new;
    logic              coll_any;

    // Writer side
    modport slave (
        input  pix_valid, pix_x, pix_dat, line_end, lb_rdat1,
        output pix_ready, line_done, lb_wadr, lb_wdat, lb_we,
               coll_valid, coll_old, coll_new, coll_any
    );

    // Renderer plus line buffer side
    modport master (
        output pix_valid, pix_x, pix_dat, line_end, lb_rdat1,
        input  pix_ready, line_done, lb_wadr, lb_wdat, lb_we,
               coll_valid, coll_old, coll_new, coll_any
    );

endinterface : sprite_line_writer_if
`default_nettype wire

// File: rtl/sprite_line_writer.sv
`default_nettype none
// ============================================================================
// Module  : sprite_line_writer
// Brief   : Read-modify-write sprite pixels into the scanline buffer; first
//           opaque pixel wins, later opaque pixels report a collision.
// Revision: 1.0 - initial release
// ============================================================================
module sprite_line_writer
    import sprite_line_writer_pkg::*;
#(
    parameter int AW     = C_AW,
    parameter int DW     = C_DW,
    parameter int CW     = C_CW,
    parameter int LINE_W = C_LINE_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sprite_line_writer_if.slave  bus
);

    localparam int          IW       = DW - CW;
    localparam logic [AW:0] LINE_LIM = (AW+1)'(LINE_W);

    state_e          state_q,      state_d;
    logic [AW-1:0]   lb_wadr_q,    lb_wadr_d;
    logic [DW-1:0]   lb_wdat_q,    lb_wdat_d;
    logic            lb_we_q,      lb_we_d;
    logic [DW-1:0]   pix_q,        pix_d;
    logic            coll_valid_q, coll_valid_d;
    logic [IW-1:0]   coll_old_q,   coll_old_d;
    logic [IW-1:0]   coll_new_q,   coll_new_d;
    logic            coll_any_q,   coll_any_d;
    logic            pending_q,    pending_d;
    logic            line_done_q,  line_done_d;

    logic            w_pix_ready;
    logic            w_accept;
    logic            w_discard;
    logic            w_done;

    // Gating with rst_n keeps ready low for the whole reset window.
    assign w_pix_ready = rst_n & ((state_q == ST_IDLE) | (state_q == ST_WR));
    assign w_accept    = bus.pix_valid & w_pix_ready;
    assign w_discard   = (bus.pix_dat[CW-1:0] == CW'(C_TRANSPARENT)) |
                         ({1'b0, bus.pix_x} >= LINE_LIM);
    // A pixel still on offer while idle is drained before the line closes.
    assign w_done      = (state_q == ST_IDLE) & pending_q & ~bus.pix_valid;

    always_comb begin
        state_d      = state_q;
        lb_wadr_d    = lb_wadr_q;
        lb_wdat_d    = lb_wdat_q;
        lb_we_d      = 1'b0;
        pix_d        = pix_q;
        coll_valid_d = 1'b0;
        coll_old_d   = coll_old_q;
        coll_new_d   = coll_new_q;
        coll_any_d   = w_done ? 1'b0 : coll_any_q;
        pending_d    = bus.line_end | (pending_q & ~w_done);
        line_done_d  = w_done;

        case (state_q)
            ST_IDLE, ST_WR: begin
                if (w_accept && !w_discard) begin
                    state_d   = ST_RD;
                    lb_wadr_d = bus.pix_x;
                    pix_d     = bus.pix_dat;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_RD: begin
                state_d = ST_CHK;
            end
            ST_CHK: begin
                if (bus.lb_rdat1[CW-1:0] == CW'(C_TRANSPARENT)) begin
                    lb_wdat_d = pix_q;
                    lb_we_d   = 1'b1;
                    state_d   = ST_WR;
                end else begin
                    coll_valid_d = 1'b1;
                    coll_old_d   = bus.lb_rdat1[DW-1:CW];
                    coll_new_d   = pix_q[DW-1:CW];
                    coll_any_d   = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lb_wadr_q    <= '0;
            lb_wdat_q    <= '0;
            lb_we_q      <= 1'b0;
            pix_q        <= '0;
            coll_valid_q <= 1'b0;
            coll_old_q   <= '0;
            coll_new_q   <= '0;
            coll_any_q   <= 1'b0;
            pending_q    <= 1'b0;
            line_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lb_wadr_q    <= lb_wadr_d;
            lb_wdat_q    <= lb_wdat_d;
            lb_we_q      <= lb_we_d;
            pix_q        <= pix_d;
            coll_valid_q <= coll_valid_d;
            coll_old_q   <= coll_old_d;
            coll_new_q   <= coll_new_d;
            coll_any_q   <= coll_any_d;
            pending_q    <= pending_d;
            line_done_q  <= line_done_d;
        end
    end

    assign bus.pix_ready  = w_pix_ready;
    assign bus.lb_wadr    = lb_wadr_q;
    assign bus.lb_wdat    = lb_wdat_q;
    assign bus.lb_we      = lb_we_q;
    assign bus.coll_valid = coll_valid_q;
    assign bus.coll_old   = coll_old_q;
    assign bus.coll_new   = coll_new_q;
    assign bus.coll_any   = coll_any_q;
    assign bus.line_done  = line_done_q;

endmodule : sprite_line_writer
`default_nettype wire

// File: tb/tb_sprite_line_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_sprite_line_writer
// Brief   : Directed bench for sprite_line_writer with a behavioural line buffer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sprite_line_writer;

    logic clk;
    logic rst_n;
    logic lb_clr;
    int   n_tests;
    int   n_fail;
    int   cyc;

    logic [10:0] ram [0:1023];
    logic [20:0] wlog [$];

    sprite_line_writer_if #(.AW(10), .DW(11), .CW(4)) bus ();

    sprite_line_writer #(.AW(10), .DW(11), .CW(4), .LINE_W(512)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line buffer: registered read-back, write on we.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lb_clr) begin
            for (int i = 0; i < 1024; i++) ram[i] <= '0;
            bus.lb_rdat1 <= '0;
        end else begin
            if (bus.lb_we) begin
                ram[bus.lb_wadr] <= bus.lb_wdat;
                wlog.push_back({bus.lb_wadr, bus.lb_wdat});
            end
            bus.lb_rdat1 <= ram[bus.lb_wadr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [9:0] x, input logic [10:0] d);
        bus.pix_valid = 1'b1;
        bus.pix_x     = x;
        bus.pix_dat   = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          prev;
        logic        seen;
        logic [9:0]  xs [4];
        logic [10:0] ds [4];

        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        lb_clr  = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_x     = '0;
        bus.pix_dat   = '0;
        bus.line_end  = 1'b0;
        repeat (3) @(negedge clk);
        lb_clr = 1'b0;

        // Reset state
        check("rst_ready",      32'(bus.pix_ready),  0);
        check("rst_we",         32'(bus.lb_we),      0);
        check("rst_done",       32'(bus.line_done),  0);
        check("rst_coll_valid", 32'(bus.coll_valid), 0);
        check("rst_coll_any",   32'(bus.coll_any),   0);
        rst_n = 1'b1;
        #1 check("rel_ready",   32'(bus.pix_ready),  1);

        // 1: write into empty slot
        @(negedge clk);
        offer(10'd5, 11'h123);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        check("t1_rd_we",    32'(bus.lb_we),     0);
        check("t1_rd_ready", 32'(bus.pix_ready), 0);
        check("t1_rd_wadr",  32'(bus.lb_wadr),   5);
        @(negedge clk);
        check("t1_chk_we",   32'(bus.lb_we),     0);
        @(negedge clk);
        check("t1_we",       32'(bus.lb_we),     1);
        check("t1_wadr",     32'(bus.lb_wadr),   5);
        check("t1_wdat",     32'(bus.lb_wdat),   32'h123);
        check("t1_wr_ready", 32'(bus.pix_ready), 1);
        @(negedge clk);
        check("t1_we_off",   32'(bus.lb_we),     0);
        check("t1_ram5",     32'(ram[5]),        32'h123);
        check("t1_no_coll",  32'(bus.coll_any),  0);

        // 2: collision on occupied slot
        offer(10'd5, 11'h2A7);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        @(negedge clk);
        check("t2_chk_cv",   32'(bus.coll_valid), 0);
        @(negedge clk);
        check("t2_cv",       32'(bus.coll_valid), 1);
        check("t2_old",      32'(bus.coll_old),   32'h12);
        check("t2_new",      32'(bus.coll_new),   32'h2A);
        check("t2_any",      32'(bus.coll_any),   1);
        check("t2_we",       32'(bus.lb_we),      0);
        check("t2_ready",    32'(bus.pix_ready),  1);
        @(negedge clk);
        check("t2_cv_pulse", 32'(bus.coll_valid), 0);
        check("t2_any_hold", 32'(bus.coll_any),   1);
        check("t2_old_hold", 32'(bus.coll_old),   32'h12);
        check("t2_ram5",     32'(ram[5]),         32'h123);

        // 3: transparent and off-line pixels are dropped
        offer(10'd3, 11'h120);
        @(negedge clk);
        check("t3a_ready", 32'(bus.pix_ready), 1);
        check("t3a_we",    32'(bus.lb_we),     0);
        offer(10'd600, 11'h155);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        check("t3b_ready", 32'(bus.pix_ready), 1);
        check("t3b_we",    32'(bus.lb_we),     0);
        @(negedge clk);
        check("t3_nwrites", 32'(wlog.size()),  1);

        // 4: back-to-back pixels with valid held, x=511 is the last visible slot
        xs[0] = 10'd10;  ds[0] = 11'h301;
        xs[1] = 10'd11;  ds[1] = 11'h302;
        xs[2] = 10'd12;  ds[2] = 11'h303;
        xs[3] = 10'd511; ds[3] = 11'h30F;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            offer(xs[i], ds[i]);
            k = 0;
            while (!bus.pix_ready && k < 8) begin
                @(negedge clk);
                k++;
            end
            if (i > 0) check("t4_interval", 32'(cyc - prev), 3);
            prev = cyc;
            @(negedge clk);
        end
        bus.pix_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_nwrites", 32'(wlog.size()), 5);
        if (wlog.size() >= 5) begin
            for (int j = 0; j < 4; j++) begin
                check("t4_wlog_adr", 32'(wlog[1+j][20:11]), 32'(xs[j]));
                check("t4_wlog_dat", 32'(wlog[1+j][10:0]),  32'(ds[j]));
            end
        end
        check("t4_ram511", 32'(ram[511]), 32'h30F);

        // 5: line_end during an RMW
        offer(10'd20, 11'h404);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.line_end  = 1'b1;
        @(negedge clk);
        bus.line_end  = 1'b0;
        check("t5_chk_done", 32'(bus.line_done), 0);
        @(negedge clk);
        check("t5_wr_done",  32'(bus.line_done), 0);
        check("t5_wr_we",    32'(bus.lb_we),     1);
        check("t5_wr_any",   32'(bus.coll_any),  1);
        @(negedge clk);
        check("t5_idle_done", 32'(bus.line_done), 0);
        check("t5_idle_any",  32'(bus.coll_any),  1);
        @(negedge clk);
        check("t5_done",     32'(bus.line_done), 1);
        check("t5_any_clr",  32'(bus.coll_any),  0);
        @(negedge clk);
        check("t5_done_off", 32'(bus.line_done), 0);
        check("t5_ram20",    32'(ram[20]),       32'h404);

        // 5b: line_end while idle with nothing in flight
        bus.line_end = 1'b1;
        @(negedge clk);
        bus.line_end = 1'b0;
        check("t5b_early", 32'(bus.line_done), 0);
        @(negedge clk);
        check("t5b_done",  32'(bus.line_done), 1);
        @(negedge clk);
        check("t5b_off",   32'(bus.line_done), 0);

        // 6: async reset during CHK, with a line_end pending
        offer(10'd30, 11'h505);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.line_end  = 1'b1;
        @(negedge clk);
        bus.line_end  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", 32'(bus.pix_ready),  0);
        check("t6_rst_we",    32'(bus.lb_we),      0);
        check("t6_rst_cv",    32'(bus.coll_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("t6_rel_ready", 32'(bus.pix_ready), 1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.line_done) seen = 1'b1;
        end
        check("t6_pending_lost", 32'(seen),         0);
        check("t6_ram30",        32'(ram[30]),      0);
        check("t6_nwrites",      32'(wlog.size()),  6);

        // 6b: async reset while the write strobe is high
        offer(10'd31, 11'h606);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6b_we_pre", 32'(bus.lb_we), 1);
        rst_n = 1'b0;
        #1 check("t6b_we_rst", 32'(bus.lb_we), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6b_ram31",  32'(ram[31]),     0);
        check("t6b_nwrites", 32'(wlog.size()), 6);

        // Recovery after reset
        offer(10'd31, 11'h606);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("t6c_ram31",   32'(ram[31]),     32'h606);
        check("t6c_nwrites", 32'(wlog.size()), 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sprite_line_writer
`default_nettype wire
